search_logic: RTL

- Lookup side of the SRL-based FracTCAM; the counterpart to the update path that writes entries.
- Slices the search key into 5-bit chunks and drives them as SRL32 read addresses.
- AND-reduces the per-chunk match bits returned by the array into a D-entry match vector.
- Priority-encodes that vector into the lowest matching index. Fully pipelined: one search per cycle, fixed latency.

---
 rtl/search_logic_pkg.sv | 16 +
 rtl/search_logic_prio_enc_grp.sv | 22 ++
 rtl/search_logic.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/search_logic_pkg.sv
// Shared constants and helpers for the FracTCAM lookup path.
package search_logic_pkg;
    localparam int CHUNK_W   = 5;
    localparam int SRL_DEPTH = 32;
    localparam int D_DEF     = 512;
    localparam int W_DEF     = 40;
    localparam int GS_DEF    = 32;
    localparam int NCH       = W_DEF / CHUNK_W;
    localparam int IDXW      = $clog2(D_DEF);
    localparam int NGRP      = D_DEF / GS_DEF;

    // Flat position of the match bit for chunk i, entry j in an array of d entries.
    function automatic int mv_bit(input int i, input int j, input int d);
        return i * d + j;
    endfunction
endpackage

// File: rtl/search_logic_prio_enc_grp.sv
// Lowest-first priority encoder with any-hit and two-or-more flags.
module prio_enc_grp
    import search_logic_pkg::*;
#(
    parameter  int N  = 32,
    localparam int OW = $clog2(N)
) (
    input  logic [N-1:0]  v,
    output logic          hit,
    output logic          multi,
    output logic [OW-1:0] off
);
    // Scan from the top so the lowest set bit wins; v & (v-1) clears the lowest set bit.
    always_comb begin
        off = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (v[i]) off = OW'(i);
        end
        hit   = |v;
        multi = |(v & (v - N'(1)));
    end
endmodule

// File: rtl/search_logic.sv
// FracTCAM lookup: key -> SRL addresses, chunk AND-reduce, two-level priority encode.
module search_logic
    import search_logic_pkg::*;
#(
    parameter int D  = D_DEF,
    parameter int W  = W_DEF,
    parameter int GS = GS_DEF
) (
    input  logic                     wclk,
    input  logic                     reset,
    input  logic                     req,
    input  logic [W-1:0]             sk,
    input  logic                     wr,
    output logic                     rdy,
    output logic [W-1:0]             addr,
    input  logic [D*W/CHUNK_W-1:0]   mv,
    output logic                     vld,
    output logic                     hit,
    output logic [$clog2(D)-1:0]     idx,
    output logic                     multi,
    output logic                     err
);
    localparam int NC = W / CHUNK_W;
    localparam int NG = D / GS;
    localparam int GW = $clog2(NG);
    localparam int OW = $clog2(GS);

    logic               acc;
    logic [2:0]         vld_pipe;   // valid after S0, S1, S2
    logic [D-1:0]       and_v;
    logic [D-1:0]       m1;
    logic               e1;
    logic [NG-1:0]      gh_c, gm_c;
    logic [NG-1:0][OW-1:0] go_c;
    logic [NG-1:0]      ghit, gmulti;
    logic [NG-1:0][OW-1:0] goff;
    logic               e2;
    logic               any_c, gmany_c;
    logic [GW-1:0]      gsel_c;
    logic [OW-1:0]      sel_off;
    logic               multi_c;

    assign rdy = ~wr;
    assign acc = req & rdy;

    // S0: capture the key as SRL read address on acceptance.
    always_ff @(posedge wclk) begin
        if (reset) addr <= '0;
        else if (acc) addr <= sk;
    end

    // Valid shift register; reset drops every in-flight search.
    always_ff @(posedge wclk) begin
        if (reset) vld_pipe <= '0;
        else       vld_pipe <= {vld_pipe[1:0], acc};
    end

    // An entry matches only if every chunk's SRL returns a match.
    for (genvar j = 0; j < D; j++) begin : g_ent
        logic [NC-1:0] col;
        for (genvar i = 0; i < NC; i++) begin : g_ch
            assign col[i] = mv[mv_bit(i, j, D)];
        end
        assign and_v[j] = &col;
    end

    // S1: register the entry match vector and whether an update overlapped the read.
    always_ff @(posedge wclk) begin
        if (reset) begin
            m1 <= '0;
            e1 <= 1'b0;
        end else begin
            m1 <= and_v;
            e1 <= wr;
        end
    end

    for (genvar g = 0; g < NG; g++) begin : g_grp
        prio_enc_grp #(.N(GS)) u_enc (
            .v     (m1[g*GS +: GS]),
            .hit   (gh_c[g]),
            .multi (gm_c[g]),
            .off   (go_c[g])
        );
    end

    // S2: register per-group hit, lowest offset and multi.
    always_ff @(posedge wclk) begin
        if (reset) begin
            ghit   <= '0;
            gmulti <= '0;
            goff   <= '0;
            e2     <= 1'b0;
        end else begin
            ghit   <= gh_c;
            gmulti <= gm_c;
            goff   <= go_c;
            e2     <= e1;
        end
    end

    prio_enc_grp #(.N(NG)) u_gsel (
        .v     (ghit),
        .hit   (any_c),
        .multi (gmany_c),
        .off   (gsel_c)
    );

    // Combine group winner with its in-group offset; GS is a power of two so concatenation is g*GS+off.
    always_comb begin
        sel_off = goff[gsel_c];
        multi_c = gmany_c | gmulti[gsel_c];
    end

    // S3: register the result; outputs other than vld hold between results.
    always_ff @(posedge wclk) begin
        if (reset) begin
            vld   <= 1'b0;
            hit   <= 1'b0;
            idx   <= '0;
            multi <= 1'b0;
            err   <= 1'b0;
        end else begin
            vld <= vld_pipe[2];
            if (vld_pipe[2]) begin
                if (e2) begin
                    hit   <= 1'b0;
                    idx   <= '0;
                    multi <= 1'b0;
                    err   <= 1'b1;
                end else begin
                    hit   <= any_c;
                    idx   <= any_c ? {gsel_c, sel_off} : '0;
                    multi <= any_c & multi_c;
                    err   <= 1'b0;
                end
            end
        end
    end
endmodule
